spawn_ctrl: RTL and testbench
=============================

# spawn_ctrl

Ball-serve controller sitting directly downstream of the spawn LFSR in the Pong datapath. On a serve request from the game FSM it captures the next random sample, legalises it into a vertical start row, and waits a fixed number of frames before presenting a complete ball start state. The ball physics block consumes that state through a valid/ack handshake.

## Interface
Parameters:
- SCREEN_W, 160, playfield width in pixels (x range 0..SCREEN_W-1)
- SCREEN_H, 120, playfield height in pixels (y range 0..SCREEN_H-1)
- BALL_SIZE, 2, ball edge length in pixels
- SERVE_FRAMES, 60, frame ticks between capture and presentation (1..255)
- MAX_REJECT, 8, rejection limit (used only with SPAWN_REJECT_EN)

Ports:
- clock  in  1  system clock, all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per video frame
- spawn_req  in  1  one-cycle serve request from game FSM
- serve_dir  in  1  serve horizontal direction: 1 = right, 0 = left
- rnd_valid  in  1  random sample strobe from spawn LFSR (done pulse)
- rnd_value  in  7  random sample from spawn LFSR
- spawn_valid  out  1  ball start state available
- spawn_ack  in  1  consumer accepts start state
- ball_x  out  8  start column
- ball_y  out  7  start row
- ball_dx  out  1  horizontal direction
- ball_dy  out  1  vertical direction: 1 = down
- busy  out  1  high whenever FSM is not IDLE
- serve_count  out  8  number of accepted serves, wraps 255 -> 0

## Operation
- Constants: Y_MAX = SCREEN_H - BALL_SIZE (118 default); X_CENTER = (SCREEN_W - BALL_SIZE)/2 (79 default).
- FSM states: IDLE, CAPTURE, DELAY, PRESENT.
- IDLE: spawn_req -> latch serve_dir, go CAPTURE. spawn_req is ignored in all other states; there is no queueing.
- CAPTURE: on the first cycle with rnd_valid=1, legalise rnd_value: y = (rnd_value > Y_MAX) ? Y_MAX : rnd_value. Set ball_dy = rnd_value[0], ball_x = X_CENTER, ball_dx = latched serve_dir. Load the delay counter with SERVE_FRAMES and go DELAY. rnd_valid outside CAPTURE is ignored.
- DELAY: decrement the counter on each frame_tick. On the tick that takes it to 0, go PRESENT.
- PRESENT: spawn_valid=1, and outputs are held stable. On spawn_ack: serve_count += 1 (mod 256) and go IDLE.
- spawn_ack outside PRESENT has no effect.
- All comparisons are unsigned at 7 bits. The counter is 8 bits.

## Timing
- Reset values: spawn_valid=0, busy=0, ball_x=0, ball_y=0, ball_dx=0, ball_dy=0, serve_count=0, state IDLE, counter 0.
- spawn_req at cycle t -> busy=1 at t+1.
- rnd_valid seen in CAPTURE at cycle c -> ball_y/x/dx/dy valid at c+1, state DELAY at c+1.
- The SERVE_FRAMES-th frame_tick at cycle f -> spawn_valid=1 at f+1.
- frame_tick coincident with the capture cycle is not counted.
- Ack at cycle a -> spawn_valid=0, busy=0, serve_count updated at a+1. A spawn_req at a+1 is accepted.
- spawn_req coincident with ack (state PRESENT) is dropped.
- resetn low at any cycle forces reset values at the next edge, regardless of state. An in-flight serve is discarded.

## Configuration
- SPAWN_REJECT_EN defined: in CAPTURE, a sample with rnd_value > Y_MAX is rejected and the FSM waits for the next rnd_valid.
  - A 3-bit reject counter tracks rejections.
  - After MAX_REJECT consecutive rejections, the next sample is clamped as in the base behaviour, so service is guaranteed.
  - The reject counter clears on entry to CAPTURE.
- SPAWN_REJECT_EN undefined: always clamp. No reject counter is built.

## Structure
- Shared package pong_pkg holds:
  - state enum spawn_state_t {IDLE, CAPTURE, DELAY, PRESENT}
  - playfield defaults SCREEN_W/SCREEN_H/BALL_SIZE
  - direction encodings DIR_RIGHT/DIR_DOWN = 1
- One sub-module is natural: spawn_delay, a loadable 8-bit frame-tick down-counter with a zero flag.
- Legalisation stays inline in spawn_ctrl.

## Test plan
- Reset mid-DELAY: assert resetn=0 for one cycle -> all outputs at reset values, busy=0, and the next spawn_req starts a fresh serve.
- Nominal serve: spawn_req, serve_dir=1; rnd_value=37 with rnd_valid two cycles later; SERVE_FRAMES=3 ticks -> spawn_valid one cycle after the 3rd tick, with ball_x=79, ball_y=37, ball_dx=1, ball_dy=1. Ack -> serve_count=1.
- Clamp: rnd_value=125 -> ball_y=118. rnd_value=118 -> ball_y=118, ball_dy=0. rnd_value=0 -> ball_y=0.
- Backpressure/ignore: hold spawn_ack=0 for 10 cycles -> spawn_valid and outputs stable. A spawn_req during DELAY/PRESENT produces no second serve. rnd_valid pulses during DELAY do not change ball_y.
- serve_count wrap: 256 acked serves -> serve_count returns to 0. Req coincident with ack is dropped; req the following cycle is accepted.
- SPAWN_REJECT_EN: samples 120, 127, 50 -> ball_y=50. Eight consecutive samples of 127, then a 9th of 127 -> ball_y=118.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared Pong datapath definitions: serve FSM states, playfield defaults and
// direction encodings.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DELAY,
        PRESENT
    } spawn_state_t;

    localparam int unsigned DEF_SCREEN_W  = 160;
    localparam int unsigned DEF_SCREEN_H  = 120;
    localparam int unsigned DEF_BALL_SIZE = 2;

    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_DOWN  = 1'b1;

endpackage

// File: rtl/spawn_delay.sv
// Loadable 8-bit frame-tick down-counter. The zero flag fires combinationally
// on the tick that brings the count from 1 to 0.
module spawn_delay (
    input  logic       clock,
    input  logic       resetn,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       tick,
    output logic       zero
);

    logic [7:0] count_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            count_q <= 8'd0;
        end else if (load) begin
            // A load beats a coincident tick, so that tick is never counted.
            count_q <= load_value;
        end else if (tick && (count_q != 8'd0)) begin
            count_q <= count_q - 8'd1;
        end
    end

    assign zero = tick && !load && (count_q == 8'd1);

endmodule

// File: rtl/spawn_ctrl.sv
// Ball-serve controller: captures an LFSR sample, legalises it into a start row,
// waits SERVE_FRAMES frames and presents it. Optional feature: SPAWN_REJECT_EN.
module spawn_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned SCREEN_W     = DEF_SCREEN_W,
    parameter int unsigned SCREEN_H     = DEF_SCREEN_H,
    parameter int unsigned BALL_SIZE    = DEF_BALL_SIZE,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned MAX_REJECT   = 8
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       frame_tick,
    input  logic       spawn_req,
    input  logic       serve_dir,
    input  logic       rnd_valid,
    input  logic [6:0] rnd_value,
    output logic       spawn_valid,
    input  logic       spawn_ack,
    output logic [7:0] ball_x,
    output logic [6:0] ball_y,
    output logic       ball_dx,
    output logic       ball_dy,
    output logic       busy,
    output logic [7:0] serve_count
);

    localparam logic [6:0] Y_MAX    = 7'(SCREEN_H - BALL_SIZE);
    localparam logic [7:0] X_CENTER = 8'((SCREEN_W - BALL_SIZE) / 2);

    if (SERVE_FRAMES < 1 || SERVE_FRAMES > 255 || MAX_REJECT < 1 || MAX_REJECT > 8)
    begin : g_param_check
        $error("spawn_ctrl: SERVE_FRAMES or MAX_REJECT out of range");
    end

    spawn_state_t state_q, state_d;
    logic         dir_q;
    logic [7:0]   ball_x_q;
    logic [6:0]   ball_y_q;
    logic         ball_dx_q;
    logic         ball_dy_q;
    logic [7:0]   serve_count_q;

    logic start;
    logic capture;
    logic over;
    logic reject;
    logic expire;

    assign start = (state_q == IDLE) && spawn_req;
    assign over  = rnd_value > Y_MAX;

`ifdef SPAWN_REJECT_EN
    logic [2:0] rej_q;
    logic       rej_full_q;

    // rej_full_q marks that MAX_REJECT rejections happened; the next sample is clamped.
    always_ff @(posedge clock) begin
        if (!resetn || start) begin
            rej_q      <= 3'd0;
            rej_full_q <= 1'b0;
        end else if (state_q == CAPTURE && rnd_valid && reject) begin
            if (rej_q == 3'(MAX_REJECT - 1)) begin
                rej_full_q <= 1'b1;
            end else begin
                rej_q <= rej_q + 3'd1;
            end
        end
    end

    assign reject = over && !rej_full_q;
`else
    assign reject = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (spawn_req) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (rnd_valid && !reject) begin
                    capture = 1'b1;
                    state_d = DELAY;
                end
            end
            DELAY: begin
                if (expire) begin
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (spawn_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q       <= IDLE;
            dir_q         <= 1'b0;
            ball_x_q      <= 8'd0;
            ball_y_q      <= 7'd0;
            ball_dx_q     <= 1'b0;
            ball_dy_q     <= 1'b0;
            serve_count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            if (start) begin
                dir_q <= serve_dir;
            end
            if (capture) begin
                ball_x_q  <= X_CENTER;
                ball_y_q  <= over ? Y_MAX : rnd_value;
                ball_dx_q <= dir_q;
                ball_dy_q <= rnd_value[0];
            end
            if (state_q == PRESENT && spawn_ack) begin
                serve_count_q <= serve_count_q + 8'd1;
            end
        end
    end

    spawn_delay u_delay (
        .clock      (clock),
        .resetn     (resetn),
        .load       (capture),
        .load_value (8'(SERVE_FRAMES)),
        .tick       (frame_tick && (state_q == DELAY)),
        .zero       (expire)
    );

    assign spawn_valid = (state_q == PRESENT);
    assign busy        = (state_q != IDLE);
    assign ball_x      = ball_x_q;
    assign ball_y      = ball_y_q;
    assign ball_dx     = ball_dx_q;
    assign ball_dy     = ball_dy_q;
    assign serve_count = serve_count_q;

endmodule

// File: tb/tb_spawn_ctrl.sv
// Self-checking bench for spawn_ctrl: directed serves plus randomized serves
// compared against a per-serve reference model of the legalisation rules.
module tb_spawn_ctrl;

    localparam int SF        = 3;
    localparam int SCR_W     = 160;
    localparam int SCR_H     = 120;
    localparam int BSZ       = 2;
    localparam int MAX_REJ   = 8;
    localparam int Y_LIM     = SCR_H - BSZ;
    localparam int X_MID     = (SCR_W - BSZ) / 2;
`ifdef SPAWN_REJECT_EN
    localparam bit REJ_MODE  = 1'b1;
`else
    localparam bit REJ_MODE  = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       resetn;
    logic       frame_tick;
    logic       spawn_req;
    logic       serve_dir;
    logic       rnd_valid;
    logic [6:0] rnd_value;
    logic       spawn_valid;
    logic       spawn_ack;
    logic [7:0] ball_x;
    logic [6:0] ball_y;
    logic       ball_dx;
    logic       ball_dy;
    logic       busy;
    logic [7:0] serve_count;

    int compared   = 0;
    int mismatched = 0;
    int cnt_exp    = 0;

    spawn_ctrl #(
        .SCREEN_W     (SCR_W),
        .SCREEN_H     (SCR_H),
        .BALL_SIZE    (BSZ),
        .SERVE_FRAMES (SF),
        .MAX_REJECT   (MAX_REJ)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .frame_tick  (frame_tick),
        .spawn_req   (spawn_req),
        .serve_dir   (serve_dir),
        .rnd_valid   (rnd_valid),
        .rnd_value   (rnd_value),
        .spawn_valid (spawn_valid),
        .spawn_ack   (spawn_ack),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .ball_dx     (ball_dx),
        .ball_dy     (ball_dy),
        .busy        (busy),
        .serve_count (serve_count)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_valid"}, 32'(spawn_valid), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_x"}, 32'(ball_x), 0);
        chk({tag, "_y"}, 32'(ball_y), 0);
        chk({tag, "_dx"}, 32'(ball_dx), 0);
        chk({tag, "_dy"}, 32'(ball_dy), 0);
        chk({tag, "_count"}, 32'(serve_count), 0);
    endtask

    task automatic chk_ball(input string tag, input int ex, input int ey, input int edx,
                            input int edy);
        chk({tag, "_x"}, 32'(ball_x), 32'(ex));
        chk({tag, "_y"}, 32'(ball_y), 32'(ey));
        chk({tag, "_dx"}, 32'(ball_dx), 32'(edx));
        chk({tag, "_dy"}, 32'(ball_dy), 32'(edy));
    endtask

    // One full serve. samples are offered in order until the model accepts one.
    task automatic serve(input string tag, input logic dir, input int samples[$],
                         input bit tick_on_capture, input int hold, input bit req_with_ack);
        int acc_idx;
        int rej;
        int v;
        int ey;
        int edy;
        acc_idx = samples.size() - 1;
        rej = 0;
        for (int i = 0; i < samples.size(); i++) begin
            if (REJ_MODE && samples[i] > Y_LIM && rej < MAX_REJ) begin
                rej++;
            end else begin
                acc_idx = i;
                break;
            end
        end
        v   = samples[acc_idx];
        ey  = (v > Y_LIM) ? Y_LIM : v;
        edy = v % 2;

        spawn_req = 1'b1;
        serve_dir = dir;
        step();
        spawn_req = 1'b0;
        serve_dir = $urandom_range(0, 1);
        chk({tag, "_busy_req"}, 32'(busy), 1);
        repeat ($urandom_range(0, 2)) begin
            frame_tick = $urandom_range(0, 1);
            step();
        end
        for (int i = 0; i <= acc_idx; i++) begin
            rnd_valid  = 1'b1;
            rnd_value  = 7'(samples[i]);
            frame_tick = (i == acc_idx) ? tick_on_capture : 1'b0;
            step();
            rnd_valid  = 1'b0;
            frame_tick = 1'b0;
            if (i < acc_idx) begin
                chk({tag, "_valid_rej"}, 32'(spawn_valid), 0);
                repeat ($urandom_range(0, 1)) step();
            end
        end
        chk_ball({tag, "_cap"}, X_MID, ey, int'(dir), edy);
        chk({tag, "_valid_cap"}, 32'(spawn_valid), 0);

        for (int t = 1; t <= SF; t++) begin
            repeat ($urandom_range(0, 2)) begin
                spawn_req = $urandom_range(0, 1);
                rnd_valid = $urandom_range(0, 1);
                rnd_value = 7'($urandom_range(0, 127));
                step();
            end
            spawn_req  = 1'b0;
            rnd_valid  = 1'b0;
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            chk({tag, "_valid_tick"}, 32'(spawn_valid), (t == SF) ? 1 : 0);
        end
        chk_ball({tag, "_pres"}, X_MID, ey, int'(dir), edy);

        for (int h = 0; h < hold; h++) begin
            spawn_req  = $urandom_range(0, 1);
            rnd_valid  = $urandom_range(0, 1);
            rnd_value  = 7'($urandom_range(0, 127));
            frame_tick = $urandom_range(0, 1);
            step();
            chk({tag, "_hold_valid"}, 32'(spawn_valid), 1);
            chk({tag, "_hold_y"}, 32'(ball_y), 32'(ey));
        end
        rnd_valid  = 1'b0;
        frame_tick = 1'b0;

        spawn_ack = 1'b1;
        spawn_req = req_with_ack;
        step();
        spawn_ack = 1'b0;
        spawn_req = 1'b0;
        cnt_exp = (cnt_exp + 1) % 256;
        chk({tag, "_valid_ack"}, 32'(spawn_valid), 0);
        chk({tag, "_busy_ack"}, 32'(busy), 0);
        chk({tag, "_count"}, 32'(serve_count), 32'(cnt_exp));
    endtask

    initial begin
        int q[$];
        resetn     = 1'b0;
        frame_tick = 1'b0;
        spawn_req  = 1'b0;
        serve_dir  = 1'b0;
        rnd_valid  = 1'b0;
        rnd_value  = 7'd0;
        spawn_ack  = 1'b0;
        repeat (2) step();
        chk_reset_values("reset");
        resetn = 1'b1;
        step();

        q = {37};
        serve("nominal", 1'b1, q, 1'b1, 0, 1'b0);

        // Reset in the middle of DELAY discards the serve and the count.
        spawn_req = 1'b1;
        serve_dir = 1'b1;
        step();
        spawn_req = 1'b0;
        rnd_valid = 1'b1;
        rnd_value = 7'd99;
        step();
        rnd_valid  = 1'b0;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        chk_reset_values("middelay");
        cnt_exp = 0;
        step();
        repeat (SF) begin
            frame_tick = 1'b1;
            step();
        end
        frame_tick = 1'b0;
        chk("postreset_idle_valid", 32'(spawn_valid), 0);

        q = {125, 40};
        serve("clamp125", 1'b0, q, 1'b0, 0, 1'b0);
        q = {118};
        serve("clamp118", 1'b1, q, 1'b0, 0, 1'b0);
        q = {0};
        serve("clamp0", 1'b0, q, 1'b0, 0, 1'b0);
        q = {127, 5};
        serve("clamp127", 1'b1, q, 1'b1, 0, 1'b1);

        q = {64};
        serve("backpressure", 1'b1, q, 1'b0, 10, 1'b0);

`ifdef SPAWN_REJECT_EN
        q = {120, 127, 50};
        serve("reject3", 1'b0, q, 1'b0, 0, 1'b0);
        q = {127, 127, 127, 127, 127, 127, 127, 127, 127};
        serve("reject9", 1'b1, q, 1'b0, 0, 1'b0);
`endif

        // Enough random serves to wrap serve_count through 255 -> 0.
        for (int s = 0; s < 260; s++) begin
            q = {};
            for (int k = 0; k < 9; k++) q.push_back(int'($urandom_range(0, 127)));
            if (cnt_exp == 0 && s > 0) chk("wrap_zero", 32'(serve_count), 0);
            if ($urandom_range(0, 3) == 0) begin
                rnd_valid = 1'b1;
                rnd_value = 7'($urandom_range(0, 127));
                frame_tick = 1'b1;
                step();
                rnd_valid  = 1'b0;
                frame_tick = 1'b0;
                chk("idle_noise_busy", 32'(busy), 0);
            end
            serve("rand", 1'($urandom_range(0, 1)), q, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
